hs_reader_fifo: RTL and testbench

- Parametrised successor to the one-way sync reader. Receives words from an upstream writer over a four-phase req/ack handshake: the writer holds data stable while req is high.
- Buffers received words in a DEPTH-entry FIFO and presents them downstream on a valid/ready stream.
- Sits on the consumer side of a handshake link. Back-pressure propagates upstream by withholding ack.

---
 rtl/hs_pkg.sv | 14 +
 rtl/hs_fifo.sv | 64 ++++++
 rtl/hs_reader_fifo.sv | 105 ++++++++++
 tb/tb_hs_reader_fifo.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// hs_pkg: handshake state encodings shared by the reader and the matching
// writer block.
//   STATE_W     width of the handshake state register
//   hs_state_t  S_IDLE (ack low, waiting for req) / S_ACK (ack high)
package hs_pkg;

  localparam int STATE_W = 1;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } hs_state_t;

endpackage

// File: rtl/hs_fifo.sv
// hs_fifo: DEPTH-entry first-word fall-through FIFO.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (pointers and count only)
//   push   write din this cycle; ignored when full
//   din    write data
//   pop    release the head entry; ignored when empty
//   dout   head entry, zero while empty
//   count  occupancy 0..DEPTH
//   full   count == DEPTH (from the registered count)
//   empty  count == 0
module hs_fifo
  import hs_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only valid entries are ever presented.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Forcing zero while empty gives a defined, stable value out of reset
  // without having to clear the storage array.
  assign dout = empty ? '0 : mem[rptr];

endmodule

// File: rtl/hs_reader_fifo.sv
// hs_reader_fifo: four-phase req/ack reader feeding a valid/ready stream
// through an hs_fifo buffer. Back-pressure is applied upstream by holding
// ack low while the FIFO is full.
// Optional macro HS_READER_SYNC_EN: adds a 2-flop synchroniser on req for
// asynchronous writers (req-to-ack latency grows by 2 cycles).
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   a          writer data, stable while req is high
//   req        writer request (four-phase)
//   ack        reader acknowledge, straight from the state register
//   out_data   head-of-FIFO word (first-word fall-through)
//   out_valid  FIFO non-empty
//   out_ready  downstream accepts out_data
//   count      FIFO occupancy 0..DEPTH
module hs_reader_fifo
  import hs_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic             req,
  output logic             ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  hs_state_t state_q;
  hs_state_t state_d;
  logic      req_s;
  logic      push;
  logic      pop;
  logic      full;
  logic      empty;

`ifdef HS_READER_SYNC_EN
  logic req_p0;
  logic req_p1;

  // Synchroniser stage boundary: req -> req_p0 -> req_p1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_p0 <= 1'b0;
      req_p1 <= 1'b0;
    end else begin
      req_p0 <= req;
      req_p1 <= req_p0;
    end
  end

  assign req_s = req_p1;
`else
  assign req_s = req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // One push per four-phase cycle: the push happens only on the IDLE->ACK
  // transition, so a req held high in S_ACK never writes again.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_s && !full) begin
          push    = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!req_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ack       = (state_q == S_ACK);
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  hs_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (a),
    .pop   (pop),
    .dout  (out_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_hs_reader_fifo.sv
// tb_hs_reader_fifo: directed bench for hs_reader_fifo (WIDTH=8, DEPTH=4).
// With HS_READER_SYNC_EN defined the req-to-ack latency expectation is 3.
module tb_hs_reader_fifo;

`ifdef HS_READER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] a;
  logic       req;
  logic       ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;

  int n_chk;
  int n_pass;

  hs_reader_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .req       (req),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Complete one four-phase transfer; ok=0 if either ack edge never arrives.
  task automatic send_word(input logic [7:0] d, output bit ok);
    int n;
    ok  = 1'b1;
    a   = d;
    req = 1'b1;
    n   = 0;
    while (!ack && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!ack) ok = 1'b0;
    req = 1'b0;
    n   = 0;
    while (ack && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (ack) ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 1'b0; a = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (ack !== 1'b0) $display("FAIL rst_ack got=%b exp=0", ack); else n_pass++;
    n_chk++; if (count !== 3'd0) $display("FAIL rst_count got=%0d exp=0", count); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if (out_data !== 8'h00) $display("FAIL rst_data got=%h exp=00", out_data); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_single();
    a = 8'hA5; req = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk); #1;
      if (i < LAT) begin
        n_chk++; if (ack !== 1'b0) $display("FAIL single_ack_early cyc=%0d got=%b exp=0", i, ack); else n_pass++;
      end else begin
        n_chk++; if (ack !== 1'b1) $display("FAIL single_ack_rise got=%b exp=1", ack); else n_pass++;
      end
    end
    n_chk++; if (out_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", out_valid); else n_pass++;
    n_chk++; if (out_data !== 8'hA5) $display("FAIL single_data got=%h exp=a5", out_data); else n_pass++;
    n_chk++; if (count !== 3'd1) $display("FAIL single_count got=%0d exp=1", count); else n_pass++;
    req = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk); #1;
      if (i < LAT) begin
        n_chk++; if (ack !== 1'b1) $display("FAIL single_ack_hold cyc=%0d got=%b exp=1", i, ack); else n_pass++;
      end else begin
        n_chk++; if (ack !== 1'b0) $display("FAIL single_ack_fall got=%b exp=0", ack); else n_pass++;
      end
    end
    // Drain the word so the next scenario starts empty.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_chk++; if (count !== 3'd0) $display("FAIL single_pop_count got=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_fill();
    bit ok;
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_word(vals[i], ok);
      n_chk++; if (ok !== 1'b1) $display("FAIL fill_handshake idx=%0d got=%b exp=1", i, ok); else n_pass++;
    end
    n_chk++; if (count !== 3'd4) $display("FAIL fill_count got=%0d exp=4", count); else n_pass++;
    a = 8'h55; req = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    #1;
    n_chk++; if (ack !== 1'b0) $display("FAIL fill_stall_ack got=%b exp=0", ack); else n_pass++;
    n_chk++; if (count !== 3'd4) $display("FAIL fill_stall_count got=%0d exp=4", count); else n_pass++;
    n_chk++; if (out_data !== 8'h11) $display("FAIL fill_head got=%h exp=11", out_data); else n_pass++;
    // Pop one: the push of 55 must wait until the edge after the pop.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_chk++; if (ack !== 1'b0) $display("FAIL fill_pop_ack got=%b exp=0", ack); else n_pass++;
    n_chk++; if (count !== 3'd3) $display("FAIL fill_pop_count got=%0d exp=3", count); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (ack !== 1'b1) $display("FAIL fill_late_ack got=%b exp=1", ack); else n_pass++;
    n_chk++; if (count !== 3'd4) $display("FAIL fill_late_count got=%0d exp=4", count); else n_pass++;
    req = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    n_chk++; if (ack !== 1'b0) $display("FAIL fill_release_ack got=%b exp=0", ack); else n_pass++;
  endtask

  task automatic test_drain();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h55;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (out_valid !== 1'b1) $display("FAIL drain_valid idx=%0d got=%b exp=1", i, out_valid); else n_pass++;
      n_chk++; if (out_data !== exp_q[i]) $display("FAIL drain_data idx=%0d got=%h exp=%h", i, out_data, exp_q[i]); else n_pass++;
      @(posedge clk); #1;
    end
    n_chk++; if (out_valid !== 1'b0) $display("FAIL drain_empty_valid got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if (count !== 3'd0) $display("FAIL drain_empty_count got=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_stream();
    logic [7:0] got [$];
    int         sent;
    int         maxc;
    bit         phase;
    got.delete();
    sent = 0; maxc = 0; phase = 1'b0;
    out_ready = 1'b1;
    a = 8'h00; req = 1'b1;
    for (int cyc = 0; cyc < 300 && got.size() < 10; cyc++) begin
      @(negedge clk);
      if (out_valid) got.push_back(out_data);
      if (int'(count) > maxc) maxc = int'(count);
      if (!phase && ack) begin
        req = 1'b0; phase = 1'b1; sent++;
      end else if (phase && !ack) begin
        if (sent < 10) begin
          a = 8'(sent); req = 1'b1;
        end
        phase = 1'b0;
      end
    end
    req = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (got.size() !== 10) $display("FAIL stream_len got=%0d exp=10", got.size()); else n_pass++;
    for (int i = 0; i < got.size(); i++) begin
      n_chk++; if (got[i] !== 8'(i)) $display("FAIL stream_order idx=%0d got=%h exp=%h", i, got[i], 8'(i)); else n_pass++;
    end
    n_chk++; if (maxc > 1) $display("FAIL stream_maxcount got=%0d exp<=1", maxc); else n_pass++;
    n_chk++; if (count !== 3'd0) $display("FAIL stream_end_count got=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    out_ready = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    send_word(8'h66, ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL mid_first_handshake got=%b exp=1", ok); else n_pass++;
    a = 8'h77; req = 1'b1;
    n = 0;
    while (!ack && n < 20) begin
      @(posedge clk); #1; n++;
    end
    n_chk++; if (ack !== 1'b1) $display("FAIL mid_in_ack got=%b exp=1", ack); else n_pass++;
    n_chk++; if (count !== 3'd2) $display("FAIL mid_pre_count got=%0d exp=2", count); else n_pass++;
    #3 reset = 1'b0;
    #1;
    n_chk++; if (ack !== 1'b0) $display("FAIL mid_rst_ack got=%b exp=0", ack); else n_pass++;
    n_chk++; if (count !== 3'd0) $display("FAIL mid_rst_count got=%0d exp=0", count); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", out_valid); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    n = 0;
    while (!ack && n < 20) begin
      @(posedge clk); #1; n++;
    end
    n_chk++; if (ack !== 1'b1) $display("FAIL mid_reack got=%b exp=1", ack); else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_chk++; if (count !== 3'd1) $display("FAIL mid_single_push got=%0d exp=1", count); else n_pass++;
    n_chk++; if (out_data !== 8'h77) $display("FAIL mid_data got=%h exp=77", out_data); else n_pass++;
    req = 1'b0;
    n = 0;
    while (ack && n < 20) begin
      @(posedge clk); #1; n++;
    end
    n_chk++; if (ack !== 1'b0) $display("FAIL mid_final_ack got=%b exp=0", ack); else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_stream();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
